registers_scoreboard: RTL and testbench

- Parametrised, clocked successor to the single-write-port register file.
- Provides two asynchronous read ports, one synchronous write port and an optional hardwired zero register.
- Adds a per-register pending-write scoreboard, so the datapath can detect RAW hazards against in-flight producers.
- Sits between decode (read and issue) and writeback (write and clear).

---
 rtl/registers_scoreboard.sv | 110 +++++++++++
 tb/tb_registers_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/registers_scoreboard.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
// Optional write-through forwarding on the read ports: define REGISTERS_BYPASS_EN.
module registers_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueRegister,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [ADDR_WIDTH:0]   pendingCount,
    output logic                  issueConflict
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  write_ok;
    logic                  issue_ok;
    logic                  conflict_now;

    always_comb begin
        write_ok     = regWrite   && !((ZERO_REG != 0) && (writeRegister == '0));
        issue_ok     = issueValid && !((ZERO_REG != 0) && (issueRegister == '0));
        conflict_now = issue_ok && pending[issueRegister]
                       && !(regWrite && (writeRegister == issueRegister));

        // Clear first, then set, so a same-index issue keeps the new producer pending.
        pending_next = pending;
        if (regWrite) begin
            pending_next[writeRegister] = 1'b0;
        end
        if (issue_ok) begin
            pending_next[issueRegister] = 1'b1;
        end

        count_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_next = count_next + (ADDR_WIDTH+1)'(pending_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending       <= '0;
            pendingCount  <= '0;
            issueConflict <= 1'b0;
        end else begin
            pending      <= pending_next;
            pendingCount <= count_next;
            if (conflict_now) begin
                issueConflict <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[writeRegister] <= writeData;
        end
    end

    always_comb begin
        readData1 = regs[readRegister1];
        hazard1   = pending[readRegister1];
`ifdef REGISTERS_BYPASS_EN
        if (write_ok && (writeRegister == readRegister1)) begin
            readData1 = writeData;
            hazard1   = 1'b0;
        end
`endif
        if ((ZERO_REG != 0) && (readRegister1 == '0)) begin
            readData1 = '0;
            hazard1   = 1'b0;
        end
    end

    always_comb begin
        readData2 = regs[readRegister2];
        hazard2   = pending[readRegister2];
`ifdef REGISTERS_BYPASS_EN
        if (write_ok && (writeRegister == readRegister2)) begin
            readData2 = writeData;
            hazard2   = 1'b0;
        end
`endif
        if ((ZERO_REG != 0) && (readRegister2 == '0)) begin
            readData2 = '0;
            hazard2   = 1'b0;
        end
    end

endmodule

// File: tb/tb_registers_scoreboard.sv
// Directed bench for registers_scoreboard: array/set-based reference model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_registers_scoreboard;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          regWrite = 1'b0;
    logic [AW-1:0] writeRegister = '0;
    logic [DW-1:0] writeData = '0;
    logic [AW-1:0] readRegister1 = '0;
    logic [AW-1:0] readRegister2 = '0;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;
    logic          issueValid = 1'b0;
    logic [AW-1:0] issueRegister = '0;
    logic          hazard1;
    logic          hazard2;
    logic [AW:0]   pendingCount;
    logic          issueConflict;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    logic [DW-1:0] mregs [NREG];
    bit            mpend [NREG];
    bit            mconf;

    registers_scoreboard #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ZERO_REG  (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .regWrite     (regWrite),
        .writeRegister(writeRegister),
        .writeData    (writeData),
        .readRegister1(readRegister1),
        .readRegister2(readRegister2),
        .readData1    (readData1),
        .readData2    (readData2),
        .issueValid   (issueValid),
        .issueRegister(issueRegister),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
        .pendingCount (pendingCount),
        .issueConflict(issueConflict)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the register file as an array, the scoreboard as a set of flags.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mregs[i] = '0;
                mpend[i] = 1'b0;
            end
            mconf = 1'b0;
        end else begin
            if (issueValid && issueRegister != 0 && mpend[issueRegister]
                && !(regWrite && writeRegister == issueRegister))
                mconf = 1'b1;
            if (regWrite) begin
                if (writeRegister != 0) mregs[writeRegister] = writeData;
                mpend[writeRegister] = 1'b0;
            end
            if (issueValid && issueRegister != 0) mpend[issueRegister] = 1'b1;
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
`ifdef REGISTERS_BYPASS_EN
        if (regWrite && writeRegister == idx) return writeData;
`endif
        return mregs[idx];
    endfunction

    function automatic logic exp_hz(input logic [AW-1:0] idx);
        if (idx == 0) return 1'b0;
`ifdef REGISTERS_BYPASS_EN
        if (regWrite && writeRegister == idx) return 1'b0;
`endif
        return mpend[idx];
    endfunction

    function automatic int exp_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(mpend[i]);
        return n;
    endfunction

    always @(negedge clock) begin
        if (model_on) begin
            chk("model_readData1", readData1, exp_data(readRegister1));
            chk("model_readData2", readData2, exp_data(readRegister2));
            chk("model_hazard1", hazard1, exp_hz(readRegister1));
            chk("model_hazard2", hazard2, exp_hz(readRegister2));
            chk("model_pendingCount", pendingCount, 64'(exp_count()));
            chk("model_issueConflict", issueConflict, mconf);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
        reset      = 1'b0;
        regWrite   = 1'b0;
        issueValid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    initial begin
        @(posedge clock);
        #1;
        reset    = 1'b0;
        model_on = 1'b1;

        // Reset state across every index
        for (int i = 0; i < NREG; i++) begin
            readRegister1 = AW'(i);
            readRegister2 = AW'(NREG - 1 - i);
            settle();
            chk("rst_readData1", readData1, 0);
            chk("rst_readData2", readData2, 0);
            chk("rst_hazard1", hazard1, 0);
            chk("rst_hazard2", hazard2, 0);
            if (i == 0) begin
                chk("rst_pendingCount", pendingCount, 0);
                chk("rst_issueConflict", issueConflict, 0);
            end
            next_cycle();
        end

        // Write/read and zero register
        regWrite = 1'b1; writeRegister = 5; writeData = 32'hDEADBEEF;
        next_cycle();
        regWrite = 1'b1; writeRegister = 0; writeData = 32'h12345678;
        next_cycle();
        readRegister1 = 5; readRegister2 = 0;
        settle();
        chk("wr_r5", readData1, 32'hDEADBEEF);
        chk("wr_r0", readData2, 0);

        // Scoreboard set then clear
        next_cycle();
        issueValid = 1'b1; issueRegister = 7;
        next_cycle();
        readRegister1 = 7;
        settle();
        chk("set_hazard1", hazard1, 1);
        chk("set_count", pendingCount, 1);
        next_cycle();
        regWrite = 1'b1; writeRegister = 7; writeData = 32'hA5;
        next_cycle();
        settle();
        chk("clr_hazard1", hazard1, 0);
        chk("clr_readData1", readData1, 32'hA5);
        chk("clr_count", pendingCount, 0);

        // Simultaneous set and clear on r9
        next_cycle();
        issueValid = 1'b1; issueRegister = 9;
        next_cycle();
        issueValid = 1'b1; issueRegister = 9;
        regWrite = 1'b1; writeRegister = 9; writeData = 32'h3;
        readRegister1 = 9;
        next_cycle();
        settle();
        chk("same_hazard1", hazard1, 1);
        chk("same_count", pendingCount, 1);
        chk("same_readData1", readData1, 32'h3);
        chk("same_conflict", issueConflict, 0);
        next_cycle();
        issueValid = 1'b1; issueRegister = 9;
        next_cycle();
        settle();
        chk("conflict_set", issueConflict, 1);
        chk("conflict_count", pendingCount, 1);
        next_cycle();
        regWrite = 1'b1; writeRegister = 9; writeData = 32'h4;

        // Set and clear on different indices
        next_cycle();
        issueValid = 1'b1; issueRegister = 13;
        next_cycle();
        issueValid = 1'b1; issueRegister = 12;
        regWrite = 1'b1; writeRegister = 13; writeData = 32'h1313;
        next_cycle();
        readRegister1 = 12; readRegister2 = 13;
        settle();
        chk("diff_hazard1", hazard1, 1);
        chk("diff_hazard2", hazard2, 0);
        chk("diff_readData2", readData2, 32'h1313);
        chk("diff_count", pendingCount, 1);

        // Clearing a register that is not pending
        next_cycle();
        regWrite = 1'b1; writeRegister = 20; writeData = 32'h2020;
        next_cycle();
        readRegister1 = 20;
        settle();
        chk("nopend_readData1", readData1, 32'h2020);
        chk("nopend_count", pendingCount, 1);
        next_cycle();
        regWrite = 1'b1; writeRegister = 12; writeData = 32'h0;

        // Same-cycle write/read on a pending register
        next_cycle();
        regWrite = 1'b1; writeRegister = 4; writeData = 32'h11;
        next_cycle();
        issueValid = 1'b1; issueRegister = 4;
        next_cycle();
        regWrite = 1'b1; writeRegister = 4; writeData = 32'h55; readRegister2 = 4;
        settle();
`ifdef REGISTERS_BYPASS_EN
        chk("byp_readData2", readData2, 32'h55);
        chk("byp_hazard2", hazard2, 0);
`else
        chk("byp_readData2", readData2, 32'h11);
        chk("byp_hazard2", hazard2, 1);
`endif
        next_cycle();
        settle();
        chk("byp_after_readData2", readData2, 32'h55);
        chk("byp_after_hazard2", hazard2, 0);
        chk("byp_after_count", pendingCount, 0);

        // Mid-operation reset
        next_cycle();
        issueValid = 1'b1; issueRegister = 1;
        next_cycle();
        issueValid = 1'b1; issueRegister = 2;
        next_cycle();
        issueValid = 1'b1; issueRegister = 3;
        next_cycle();
        readRegister1 = 2;
        settle();
        chk("pre_rst_count", pendingCount, 3);
        chk("pre_rst_hazard1", hazard1, 1);
        next_cycle();
        reset = 1'b1;
        issueValid = 1'b1; issueRegister = 4;
        regWrite = 1'b1; writeRegister = 10; writeData = 32'hBAD;
        readRegister1 = 3; readRegister2 = 1;
        next_cycle();
        readRegister1 = 4; readRegister2 = 10;
        settle();
        chk("mid_rst_count", pendingCount, 0);
        chk("mid_rst_conflict", issueConflict, 0);
        chk("mid_rst_hazard_r4", hazard1, 0);
        chk("mid_rst_data_r10", readData2, 0);
        next_cycle();
        readRegister1 = 5; readRegister2 = 1;
        settle();
        chk("mid_rst_data_r5", readData1, 0);
        chk("mid_rst_hazard_r1", hazard2, 0);

        // Zero register never pends and never conflicts
        next_cycle();
        issueValid = 1'b1; issueRegister = 0;
        next_cycle();
        issueValid = 1'b1; issueRegister = 0;
        readRegister1 = 0;
        next_cycle();
        settle();
        chk("zero_count", pendingCount, 0);
        chk("zero_hazard1", hazard1, 0);
        chk("zero_conflict", issueConflict, 0);

        next_cycle();
        next_cycle();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
